// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, legal opcode range and the
// opcode enumeration used by both the issue queue and the ALU itself.
package alu_pkg;

    localparam int OPCODE_W       = 4;
    localparam int DEFAULT_DATA_W = 16;

    // Highest opcode the ALU implements; anything above is rejected.
    localparam logic [OPCODE_W-1:0] OP_MAX_LEGAL = 4'd7;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7
    } alu_op_e;

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/alu_issue_mem.sv
// Entry storage for the ALU issue queue: one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset;
// the queue pointers alone decide which entries are meaningful.
module alu_issue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the pushed entry into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the ALU. Buffers up to DEPTH operations
// {opcode, A, B} and presents the oldest one show-ahead.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising CLK edge. in_ready depends only on occupancy (no pop
// lookahead); out_valid depends only on occupancy and Enable; neither valid
// may depend on the matching ready. An illegal opcode offer still completes
// its handshake but is not stored, and sets the sticky illegal_err.
// flush wins over any same-cycle push or pop.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_W-1:0]      in_opcode,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic                     flush,
    input  logic                     Enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_W-1:0]      Opcode,
    output logic [DATA_W-1:0]        Data_A,
    output logic [DATA_W-1:0]        Data_B,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OPCODE_W + 2 * DATA_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             illegal_q, illegal_d;
    logic [ENT_W-1:0] last_q,   last_d;

    logic             offer_accepted;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [ENT_W-1:0] rd_data;
    logic [ENT_W-1:0] head;

    assign not_empty      = (count_q != '0);
    assign in_ready       = (count_q < DEPTH_C);
    assign out_valid      = not_empty && Enable;
    assign offer_accepted = in_valid && in_ready;
    assign push           = offer_accepted && op_is_legal(in_opcode) && !flush;
    assign pop            = out_valid && out_ready && !flush;

    alu_issue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_opcode, in_a, in_b}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // While empty, keep showing the last head seen (0 straight after reset).
    assign head                     = not_empty ? rd_data : last_q;
    assign {Opcode, Data_A, Data_B} = head;
    assign count                    = count_q;
    assign illegal_err              = illegal_q;

    // Next-state for pointers, occupancy, error flag and held head value.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        last_d    = last_q;

        if (not_empty) begin
            last_d = rd_data;
        end

        if (offer_accepted && !op_is_legal(in_opcode)) begin
            illegal_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            last_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: reset checks, a fixed vector table from reset,
// directed multi-cycle sequences and randomized traffic against a queue model.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          flush;
    logic          Enable;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    Opcode;
    logic [DW-1:0] Data_A;
    logic [DW-1:0] Data_B;
    logic [2:0]    count;
    logic          illegal_err;

    always #5 CLK = ~CLK;

    alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .flush       (flush),
        .Enable      (Enable),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Opcode      (Opcode),
        .Data_A      (Data_A),
        .Data_B      (Data_B),
        .count       (count),
        .illegal_err (illegal_err)
    );

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } ent_t;

    // Behavioural model: a plain FIFO of entries plus the sticky flag.
    ent_t model_q[$];
    ent_t last_head;
    logic model_err;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        last_head = '0;
        model_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        ent_t exp_head;
        exp_head = (model_q.size() != 0) ? model_q[0] : last_head;
        chk({tag, " count"},     64'(count),       64'(model_q.size()));
        chk({tag, " in_ready"},  64'(in_ready),    64'(model_q.size() < DEPTH));
        chk({tag, " out_valid"}, 64'(out_valid),   64'((model_q.size() != 0) && Enable));
        chk({tag, " head"},      64'({Opcode, Data_A, Data_B}), 64'(exp_head));
        chk({tag, " illegal"},   64'(illegal_err), 64'(model_err));
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic ordy, input logic en,
                       input logic fl);
        logic acc;
        logic popv;
        ent_t e;
        in_valid  = v;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        Enable    = en;
        flush     = fl;
        @(negedge CLK);
        check_model("cyc");
        acc  = v && (model_q.size() < DEPTH);
        popv = (model_q.size() != 0) && en && ordy;
        if (model_q.size() != 0) last_head = model_q[0];
        if (acc && op > 4'd7) model_err = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (popv) void'(model_q.pop_front());
            if (acc && op <= 4'd7) begin
                e.op = op;
                e.a  = a;
                e.b  = b;
                model_q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        Enable    = 1'b1;
        flush     = 1'b0;
    endtask

    // Assert reset in the middle of a cycle and check its immediate effect.
    task automatic reset_mid();
        idle_inputs();
        RST = 1'b0;
        #1;
        chk("rst count",     64'(count),     64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst illegal",   64'(illegal_err), 64'd0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic          v;
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ordy;
        logic          en;
        logic          fl;
        logic [2:0]    e_cnt;
        logic          e_ov;
        logic          e_ir;
        logic [3:0]    e_op;
        logic [DW-1:0] e_a;
        logic [DW-1:0] e_b;
        logic          e_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Vectors applied one per cycle from reset; expectations are the
        // outputs seen before that cycle's edge.
        tbl[0] = '{1'b1, 4'd0, 16'd1, 16'd2,  1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 16'd0, 16'd0, 1'b0};
        tbl[1] = '{1'b1, 4'd1, 16'd3, 16'd4,  1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 4'd0, 16'd1, 16'd2, 1'b0};
        tbl[2] = '{1'b1, 4'd4, 16'd5, 16'd6,  1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 4'd0, 16'd1, 16'd2, 1'b0};
        tbl[3] = '{1'b0, 4'd0, 16'd0, 16'd0,  1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 4'd1, 16'd3, 16'd4, 1'b0};
        tbl[4] = '{1'b1, 4'hA, 16'd7, 16'd8,  1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 4'd4, 16'd5, 16'd6, 1'b0};
        tbl[5] = '{1'b0, 4'd0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 4'd4, 16'd5, 16'd6, 1'b1};
        tbl[6] = '{1'b0, 4'd0, 16'd0, 16'd0,  1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 4'd4, 16'd5, 16'd6, 1'b1};
        tbl[7] = '{1'b0, 4'd0, 16'd0, 16'd0,  1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd4, 16'd5, 16'd6, 1'b1};
        tbl[8] = '{1'b1, 4'd6, 16'd9, 16'd10, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 4'd4, 16'd5, 16'd6, 1'b1};
        tbl[9] = '{1'b0, 4'd0, 16'd0, 16'd0,  1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'd4, 16'd5, 16'd6, 1'b1};

        // Power-on reset
        idle_inputs();
        RST = 1'b0;
        model_reset();
        #1;
        chk("por count",     64'(count),     64'd0);
        chk("por out_valid", 64'(out_valid), 64'd0);
        chk("por in_ready",  64'(in_ready),  64'd1);
        chk("por illegal",   64'(illegal_err), 64'd0);
        chk("por head",      64'({Opcode, Data_A, Data_B}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].v;
            in_opcode = tbl[i].op;
            in_a      = tbl[i].a;
            in_b      = tbl[i].b;
            out_ready = tbl[i].ordy;
            Enable    = tbl[i].en;
            flush     = tbl[i].fl;
            @(negedge CLK);
            chk($sformatf("tbl%0d count", i),     64'(count),       64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d out_valid", i), 64'(out_valid),   64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d in_ready", i),  64'(in_ready),    64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d head", i),      64'({Opcode, Data_A, Data_B}),
                64'({tbl[i].e_op, tbl[i].e_a, tbl[i].e_b}));
            chk($sformatf("tbl%0d illegal", i),   64'(illegal_err), 64'(tbl[i].e_err));
            @(posedge CLK);
            #1;
        end
        reset_mid();

        // Reset mid-stream with three entries and the error flag set
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i), DW'(100 + i), DW'(200 + i), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'hB, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst count", 64'(count), 64'd3);
        chk("pre_rst illegal", 64'(illegal_err), 64'd1);
        reset_mid();
        cyc(1'b1, 4'd0, 16'd6464, 16'd4646, 1'b0, 1'b1, 1'b0);
        chk("first_push out_valid", 64'(out_valid), 64'd1);
        chk("first_push data", 64'({Data_A, Data_B}), 64'({16'd6464, 16'd4646}));
        cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);

        // Fill to DEPTH, refused fifth offer, drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(7 - i), DW'(16'h1110 + i), DW'(16'h2220 + i), 1'b0, 1'b1, 1'b0);
        chk("full count", 64'(count), 64'd4);
        chk("full in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 4'd2, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        chk("full fifth count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);

        // Continuous push and pop at count=2 across the pointer wrap
        for (int i = 0; i < 2; i++) cyc(1'b1, 4'd3, DW'(16'h3000 + i), DW'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'(i % 8), DW'(16'h4000 + i), DW'(16'h5000 + i), 1'b1, 1'b1, 1'b0);
            chk($sformatf("stream%0d count", i), 64'(count), 64'd2);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);

        // Illegal opcode: dropped, sticky through flush
        cyc(1'b1, 4'd5, 16'h0042, 16'h0024, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'hA, 16'h0BAD, 16'h0BAD, 1'b0, 1'b1, 1'b0);
        chk("illegal count", 64'(count), 64'd1);
        chk("illegal flag", 64'(illegal_err), 64'd1);
        cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
        chk("illegal after flush", 64'(illegal_err), 64'd1);
        chk("flush count", 64'(count), 64'd0);

        // Enable low holds contents; flush beats a same-cycle push
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd1, DW'(16'h6000 + i), DW'(16'h7000 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("disable%0d count", i), 64'(count), 64'd3);
        end
        cyc(1'b1, 4'd2, 16'h8888, 16'h9999, 1'b0, 1'b1, 1'b1);
        chk("flush_push count", 64'(count), 64'd0);
        chk("flush_push out_valid", 64'(out_valid), 64'd0);
        cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic against the model
        reset_mid();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), DW'($urandom),
                DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 29) == 0);
            if (i == 200) reset_mid();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
